ats21_cmd_issuer: RTL
=====================

Name: ats21_cmd_issuer

Overview:
Host-side initiator for the ATS21 alarm/timer control interface. Accepts 32-bit commands for channel A and channel B, queues each channel in its own FIFO, and serialises them onto the 16-bit req/ctrlA/ctrlB/ready interface. Each command goes out as two beats: upper half first, then lower half. Sits between the host or test sequencer and the alarm/timer block; drives that block's req, ctrlA and ctrlB inputs and observes its ready output.

Parameters:
DEPTH, 4, entries per channel FIFO; power of 2, at least 2
CW, 32, command width; fixed, and the split is always [31:16] then [15:0]

Ports:
clk  in  1  system clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
cmd_valid_a  in  1  host offers a channel-A command
cmd_a  in  32  A command: [31:29] opcode, [28:24] index, [23:16] flags/source, [15:0] value
cmd_ready_a  out  1  A FIFO can accept a command (not full)
cmd_valid_b  in  1  host offers a channel-B command
cmd_b  in  32  B command, same layout as cmd_a
cmd_ready_b  out  1  B FIFO can accept a command
ready  in  1  target accepts a beat when high
req  out  1  beat valid
ctrlA  out  16  channel-A beat data
ctrlB  out  16  channel-B beat data
busy  out  1  a pair is in flight, or either FIFO is non-empty
err_illegal_a  out  1  one-cycle pulse: A push dropped because opcode was 3'b100
err_illegal_b  out  1  one-cycle pulse: B push dropped because opcode was 3'b100

Behaviour:
- Reset (asynchronous; also applies mid-operation):
  - FIFOs emptied; FSM to IDLE; hold registers cleared.
  - req=0, ctrlA=0, ctrlB=0, busy=0, err_illegal_a/b=0.
  - cmd_ready_a/b=1 once reset is deasserted.
  - Any partially sent pair is abandoned and is not resent.
- Push:
  - A push happens when cmd_valid_x && cmd_ready_x at posedge.
  - cmd_ready_x = !full_x, with no bypass, so a push while full is impossible even if a pop occurs in the same cycle.
  - Opcode 3'b100 is illegal: the command is accepted (handshake completes) but not written, and err_illegal_x=1 in the next cycle only.
  - Opcodes 000, 001, 010, 011, 101, 110, 111 are stored unchanged.
- FSM, registered outputs, states IDLE, UPPER, LOWER:
  - IDLE: req=0.
    - If ready && (!empty_a || !empty_b): pop the head of each non-empty FIFO into hold_a/hold_b; an empty channel gets 32'h0 (nop). Go to UPPER.
  - UPPER: req=1, ctrlA=hold_a[31:16], ctrlB=hold_b[31:16].
    - If ready, go to LOWER; otherwise hold all outputs stable.
  - LOWER: req=1, ctrlA=hold_a[15:0], ctrlB=hold_b[15:0].
    - If ready, go to IDLE; otherwise hold.
  - At least one req=0 cycle separates consecutive pairs, so the target's upper/lower phase can never desynchronise.
- Ordering and pairing:
  - Per-channel order is preserved.
  - A and B heads are paired opportunistically; neither channel waits for the other.
- Latency: with an empty FIFO, IDLE and ready=1, a push at edge t gives:
  - hold loaded at t+1;
  - upper beat accepted at t+2;
  - lower beat accepted at t+3;
  - req=0 after t+3.
- ready low during UPPER or LOWER: the beat is held indefinitely; no timeout.
- busy = (state != IDLE) || !empty_a || !empty_b.
- Pointers: $clog2(DEPTH) bits with an extra wrap bit for the full/empty distinction; they wrap modulo DEPTH.

Optional Feature:
- Macro ATS21_ISSUE_CNT_EN.
- When defined:
  - Adds outputs issued_cnt_a[15:0] and issued_cnt_b[15:0].
  - Each counts pairs completed (LOWER accepted) whose hold for that channel was a real popped command, not a nop fill.
  - Counters wrap at 16'hFFFF→0 and reset to 0.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Decomposition:
- Package ats21_pkg holds:
  - opcode_t enum: NOP=000, SET_CLK=001, CLK_EN=010, SET_MODE=011, SET_ALARM=101, SET_TIMER=110, AT_EN=111;
  - the OP_ILLEGAL=3'b100 constant;
  - field-position localparams for opcode, index, flags and value;
  - issuer_state_t enum {IDLE, UPPER, LOWER}.
- One sub-module, ats21_cmd_fifo (synchronous FIFO, DEPTH and width parameters), instantiated twice: once for A, once for B.

Test Plan:
- Single A push: cmd_a=32'h2A80_0005, ready=1 → ctrlA=16'h2A80 with req=1 at t+2 and ctrlA=16'h0005 at t+3; ctrlB=0 on both beats; err_illegal_a never set.
- Simultaneous push: A=32'h3000_0003 and B=32'hA140_00FF → one pair; upper beat ctrlA=16'h3000, ctrlB=16'hA140; lower beat 16'h0003/16'h00FF.
- Illegal opcode: cmd_a=32'h8000_1234 → cmd_ready_a=1, err_illegal_a pulses exactly 1 cycle, FIFO stays empty, req stays 0.
- Backpressure: ready=0 for 5 cycles in UPPER, then ready=1 → ctrlA/ctrlB stable for all 5 cycles; LOWER follows; exactly 2 accepted beats.
- Full FIFO: push 4 A commands with ready=0 → cmd_ready_a=0 after the 4th; a 5th push is not taken; releasing ready issues all 4 in order with a req=0 gap between pairs.
- Reset mid-LOWER: assert reset asynchronously → req=0 immediately, busy=0, FIFOs empty; with ATS21_ISSUE_CNT_EN, counters read 0.

Source files
------------

// File: rtl/ats21_pkg.sv
// Shared types and field positions for the ATS21 command issuer.
package ats21_pkg;

  typedef enum logic [2:0] {
    NOP       = 3'b000,
    SET_CLK   = 3'b001,
    CLK_EN    = 3'b010,
    SET_MODE  = 3'b011,
    SET_ALARM = 3'b101,
    SET_TIMER = 3'b110,
    AT_EN     = 3'b111
  } opcode_t;

  localparam logic [2:0] OP_ILLEGAL = 3'b100;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 29;
  localparam int unsigned IDX_MSB = 28;
  localparam int unsigned IDX_LSB = 24;
  localparam int unsigned FLG_MSB = 23;
  localparam int unsigned FLG_LSB = 16;
  localparam int unsigned VAL_MSB = 15;
  localparam int unsigned VAL_LSB = 0;

  typedef enum logic [1:0] {IDLE, UPPER, LOWER} issuer_state_t;

  function automatic logic is_illegal(input logic [31:0] cmd);
    return cmd[OPC_MSB:OPC_LSB] == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head is visible combinationally on rd_data.
module ats21_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_wr, do_rd;

  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    empty    = (wr_ptr_q == rd_ptr_q);
    do_wr    = wr_en && !full;
    do_rd    = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    rd_data  = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/ats21_cmd_issuer.sv
// ATS21 host-side issuer: per-channel FIFOs, two-beat upper/lower serialisation.
// Optional per-channel issued-pair counters with macro ATS21_ISSUE_CNT_EN.
module ats21_cmd_issuer
  import ats21_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid_a,
  input  logic [CW-1:0] cmd_a,
  output logic          cmd_ready_a,
  input  logic          cmd_valid_b,
  input  logic [CW-1:0] cmd_b,
  output logic          cmd_ready_b,
  input  logic          ready,
  output logic          req,
  output logic [15:0]   ctrlA,
  output logic [15:0]   ctrlB,
  output logic          busy,
  output logic          err_illegal_a,
  output logic          err_illegal_b
`ifdef ATS21_ISSUE_CNT_EN
  ,
  output logic [15:0]   issued_cnt_a,
  output logic [15:0]   issued_cnt_b
`endif
);

  issuer_state_t state_q, state_d;
  logic [CW-1:0] hold_a_q, hold_a_d, hold_b_q, hold_b_d;
  logic          real_a_q, real_a_d, real_b_q, real_b_d;
  logic          err_a_q, err_a_d, err_b_q, err_b_d;
  logic          ill_a, ill_b, wr_a, wr_b, pop_a, pop_b;
  logic [CW-1:0] head_a, head_b;
  logic          full_a, full_b, empty_a, empty_b;

  ats21_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo_a (
    .clk(clk), .reset(reset), .wr_en(wr_a), .wr_data(cmd_a), .rd_en(pop_a),
    .rd_data(head_a), .full(full_a), .empty(empty_a)
  );

  ats21_cmd_fifo #(.DEPTH(DEPTH), .W(CW)) u_fifo_b (
    .clk(clk), .reset(reset), .wr_en(wr_b), .wr_data(cmd_b), .rd_en(pop_b),
    .rd_data(head_b), .full(full_b), .empty(empty_b)
  );

  always_comb begin
    cmd_ready_a = !full_a;
    cmd_ready_b = !full_b;
    // Illegal opcodes complete the handshake but never reach the FIFO.
    ill_a   = cmd_valid_a && cmd_ready_a && is_illegal(cmd_a);
    ill_b   = cmd_valid_b && cmd_ready_b && is_illegal(cmd_b);
    wr_a    = cmd_valid_a && cmd_ready_a && !ill_a;
    wr_b    = cmd_valid_b && cmd_ready_b && !ill_b;
    err_a_d = ill_a;
    err_b_d = ill_b;

    state_d  = state_q;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    real_a_d = real_a_q;
    real_b_d = real_b_q;
    pop_a    = 1'b0;
    pop_b    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready && (!empty_a || !empty_b)) begin
          pop_a    = !empty_a;
          pop_b    = !empty_b;
          hold_a_d = empty_a ? '0 : head_a;
          hold_b_d = empty_b ? '0 : head_b;
          real_a_d = !empty_a;
          real_b_d = !empty_b;
          state_d  = UPPER;
        end
      end
      UPPER:   if (ready) state_d = LOWER;
      LOWER:   if (ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req   = (state_q != IDLE);
    busy  = (state_q != IDLE) || !empty_a || !empty_b;
    ctrlA = '0;
    ctrlB = '0;
    if (state_q == UPPER) begin
      ctrlA = hold_a_q[OPC_MSB:FLG_LSB];
      ctrlB = hold_b_q[OPC_MSB:FLG_LSB];
    end else if (state_q == LOWER) begin
      ctrlA = hold_a_q[VAL_MSB:VAL_LSB];
      ctrlB = hold_b_q[VAL_MSB:VAL_LSB];
    end
    err_illegal_a = err_a_q;
    err_illegal_b = err_b_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      hold_a_q <= '0;
      hold_b_q <= '0;
      real_a_q <= 1'b0;
      real_b_q <= 1'b0;
      err_a_q  <= 1'b0;
      err_b_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      real_a_q <= real_a_d;
      real_b_q <= real_b_d;
      err_a_q  <= err_a_d;
      err_b_q  <= err_b_d;
    end
  end

`ifdef ATS21_ISSUE_CNT_EN
  logic [15:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic        done;

  always_comb begin
    done    = (state_q == LOWER) && ready;
    cnt_a_d = cnt_a_q + {15'd0, done && real_a_q};
    cnt_b_d = cnt_b_q + {15'd0, done && real_b_q};
    issued_cnt_a = cnt_a_q;
    issued_cnt_b = cnt_b_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
    end
  end
`endif

endmodule
